mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL take parameter MEM_BYTES, default 256: data-memory size in bytes, a power of two.
REQ-002 SHALL take parameter ADDR_BITS, default 8: log2(MEM_BYTES), the low address bits used for indexing.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port next_pcEXMEM, input, 64: branch target from the EX/MEM register.
REQ-006 SHALL have port alu_resultEXMEM, input, 64: memory byte address, or the ALU result for non-memory instructions.
REQ-007 SHALL have port write_dataEXMEM, input, 64: store data (forwarded rs2).
REQ-008 SHALL have port rdEXMEM, input, 5: destination register.
REQ-009 SHALL have ports MemtoRegEXMEM, RegWriteEXMEM, BranchEXMEM, MemWriteEXMEM, MemReadEXMEM, input, 1 each: control bits.
REQ-010 SHALL have ports zeroEXMEM and lessEXMEM, input, 1 each: ALU flags.
REQ-011 SHALL have port funct3EXMEM, input, 3: access size and sign, or branch condition.
REQ-012 SHALL have port pc_src, output, 1: branch taken; combinational.
REQ-013 SHALL have port branch_target, output, 64: equals next_pcEXMEM; combinational.
REQ-014 SHALL have ports read_dataMEMWB and alu_resultMEMWB, output, 64 each: registered.
REQ-015 SHALL have port rdMEMWB, output, 5: registered.
REQ-016 SHALL have ports MemtoRegMEMWB and RegWriteMEMWB, output, 1 each: registered.
REQ-017 SHALL have port wb_data, output, 64: read_dataMEMWB when MemtoRegMEMWB=1, else alu_resultMEMWB; combinational; feeds writeback and forwarding.

Function
REQ-018 SHALL form the memory index as alu_resultEXMEM[ADDR_BITS-1:0]; byte i of an access SHALL be at (index+i) mod MEM_BYTES, little-endian, so accesses wrap at the top of memory and misaligned accesses are legal.
REQ-019 SHALL store on the rising CLK edge when MemWriteEXMEM=1 and RST=1; funct3 000/001/010/011 writes the low 1/2/4/8 bytes of write_dataEXMEM; funct3 1xx writes nothing.
REQ-020 SHALL decode loads as: 000 lb (sign), 001 lh (sign), 010 lw (sign), 011 ld, 100 lbu, 101 lhu, 110 lwu (zero-extend), 111 returns 0.
REQ-021 SHALL load into read_dataMEMWB at the rising edge when MemReadEXMEM=1, and SHALL load 0 when MemReadEXMEM=0.
REQ-022 SHALL return pre-write memory contents for a load when a load and a store to overlapping bytes occur in the same cycle (read-before-write).
REQ-023 SHALL compute pc_src = BranchEXMEM AND cond, where cond by funct3 is: 000 zero; 001 !zero; 100 less; 101 !less; 110 less; 111 !less; 010/011 0.
REQ-024 SHALL register alu_resultEXMEM, rdEXMEM, MemtoRegEXMEM and RegWriteEXMEM into the corresponding MEMWB outputs every rising edge, with one-cycle latency, no enable and no stall.
REQ-025 SHALL keep pc_src and branch_target free of any dependency on memory contents or on MEMWB state.

Reset
REQ-026 SHALL asynchronously clear read_dataMEMWB, alu_resultMEMWB, rdMEMWB, MemtoRegMEMWB and RegWriteMEMWB to 0 while RST=0; wb_data therefore reads 0.
REQ-027 SHALL NOT clear or initialise memory contents on reset; contents SHALL be preserved across reset.
REQ-028 SHALL suppress all stores while RST=0, including a store pending when reset asserts mid-cycle.
REQ-029 SHALL resume normal capture on the first rising edge after RST rises.

Verification
REQ-030 SHALL cover: sd 0x8877665544332211 at addr 0x10, then ld 0x10 -> read_dataMEMWB=0x8877665544332211 one cycle after the ld; lbu 0x17 -> 0x88; lb 0x17 -> 0xFFFFFFFFFFFFFF88.
REQ-031 SHALL cover: sw 0xDEADBEEF at addr 0xFE (wrap) -> bytes FE=EF, FF=BE, 00=AD, 01=DE; lwu 0xFE -> 0x00000000DEADBEEF; lw 0xFE -> 0xFFFFFFFFDEADBEEF.
REQ-032 SHALL cover: same-cycle lb and sb to addr 0x20 holding 0x11, store data 0x22 -> load returns 0x11; next lb 0x20 -> 0x22.
REQ-033 SHALL cover: BranchEXMEM=1 across funct3 000/001/100/101 with zero/less in {0,1} -> pc_src per REQ-023; branch_target=next_pcEXMEM; BranchEXMEM=0 -> pc_src=0.
REQ-034 SHALL cover: RegWrite=1, MemtoReg=0, rd=5, alu=0x1234 -> next cycle wb_data=0x1234, rdMEMWB=5; then RST low with a store of 0xAA to 0x30 pending -> outputs 0 immediately and byte 0x30 unchanged.
REQ-035 SHALL cover: reset asserted and released after a store -> previously stored memory still reads back correctly.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressed data memory with wrapping, misaligned
// little-endian access, branch resolution and the MEM/WB pipeline register.
module mem_stage #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] next_pcEXMEM,
    input  logic [63:0] alu_resultEXMEM,
    input  logic [63:0] write_dataEXMEM,
    input  logic [4:0]  rdEXMEM,
    input  logic        MemtoRegEXMEM,
    input  logic        RegWriteEXMEM,
    input  logic        BranchEXMEM,
    input  logic        MemWriteEXMEM,
    input  logic        MemReadEXMEM,
    input  logic        zeroEXMEM,
    input  logic        lessEXMEM,
    input  logic [2:0]  funct3EXMEM,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic [63:0] read_dataMEMWB,
    output logic [63:0] alu_resultMEMWB,
    output logic [4:0]  rdMEMWB,
    output logic        MemtoRegMEMWB,
    output logic        RegWriteMEMWB,
    output logic [63:0] wb_data
);

    logic [7:0]           mem [MEM_BYTES];
    logic [ADDR_BITS-1:0] idx;
    logic [63:0]          raw;
    logic [63:0]          load_val;
    logic [7:0]           wmask;
    logic                 cond;

    assign idx = alu_resultEXMEM[ADDR_BITS-1:0];

    // Gather eight consecutive bytes; the index cast makes accesses wrap.
    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem[ADDR_BITS'(idx + i)];
        end
    end

    always_comb begin
        case (funct3EXMEM)
            3'b000:  load_val = {{56{raw[7]}},  raw[7:0]};
            3'b001:  load_val = {{48{raw[15]}}, raw[15:0]};
            3'b010:  load_val = {{32{raw[31]}}, raw[31:0]};
            3'b011:  load_val = raw;
            3'b100:  load_val = {56'd0, raw[7:0]};
            3'b101:  load_val = {48'd0, raw[15:0]};
            3'b110:  load_val = {32'd0, raw[31:0]};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        case (funct3EXMEM)
            3'b000:  wmask = 8'h01;
            3'b001:  wmask = 8'h03;
            3'b010:  wmask = 8'h0F;
            3'b011:  wmask = 8'hFF;
            default: wmask = 8'h00;
        endcase
    end

    always_comb begin
        case (funct3EXMEM)
            3'b000:         cond = zeroEXMEM;
            3'b001:         cond = ~zeroEXMEM;
            3'b100, 3'b110: cond = lessEXMEM;
            3'b101, 3'b111: cond = ~lessEXMEM;
            default:        cond = 1'b0;
        endcase
    end

    assign pc_src        = BranchEXMEM & cond;
    assign branch_target = next_pcEXMEM;

    // Memory shares the reset-sensitive block so a store is dropped whenever
    // reset is low at the edge; the reset branch leaves the contents alone.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            read_dataMEMWB  <= '0;
            alu_resultMEMWB <= '0;
            rdMEMWB         <= '0;
            MemtoRegMEMWB   <= 1'b0;
            RegWriteMEMWB   <= 1'b0;
        end else begin
            read_dataMEMWB  <= MemReadEXMEM ? load_val : '0;
            alu_resultMEMWB <= alu_resultEXMEM;
            rdMEMWB         <= rdEXMEM;
            MemtoRegMEMWB   <= MemtoRegEXMEM;
            RegWriteMEMWB   <= RegWriteEXMEM;
            if (MemWriteEXMEM) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    if (wmask[i]) begin
                        mem[ADDR_BITS'(idx + i)] <= write_dataEXMEM[8*i +: 8];
                    end
                end
            end
        end
    end

    assign wb_data = MemtoRegMEMWB ? read_dataMEMWB : alu_resultMEMWB;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: branch vector table, directed memory and
// reset sequences, and randomized traffic against a byte-array reference model.
module tb_mem_stage;

    localparam int MB = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [63:0] next_pcEXMEM = '0;
    logic [63:0] alu_resultEXMEM = '0;
    logic [63:0] write_dataEXMEM = '0;
    logic [4:0]  rdEXMEM = '0;
    logic        MemtoRegEXMEM = 1'b0;
    logic        RegWriteEXMEM = 1'b0;
    logic        BranchEXMEM = 1'b0;
    logic        MemWriteEXMEM = 1'b0;
    logic        MemReadEXMEM = 1'b0;
    logic        zeroEXMEM = 1'b0;
    logic        lessEXMEM = 1'b0;
    logic [2:0]  funct3EXMEM = '0;
    logic        pc_src;
    logic [63:0] branch_target;
    logic [63:0] read_dataMEMWB;
    logic [63:0] alu_resultMEMWB;
    logic [4:0]  rdMEMWB;
    logic        MemtoRegMEMWB;
    logic        RegWriteMEMWB;
    logic [63:0] wb_data;

    mem_stage #(.MEM_BYTES(256), .ADDR_BITS(8)) dut (
        .CLK(CLK), .RST(RST),
        .next_pcEXMEM(next_pcEXMEM), .alu_resultEXMEM(alu_resultEXMEM),
        .write_dataEXMEM(write_dataEXMEM), .rdEXMEM(rdEXMEM),
        .MemtoRegEXMEM(MemtoRegEXMEM), .RegWriteEXMEM(RegWriteEXMEM),
        .BranchEXMEM(BranchEXMEM), .MemWriteEXMEM(MemWriteEXMEM),
        .MemReadEXMEM(MemReadEXMEM), .zeroEXMEM(zeroEXMEM), .lessEXMEM(lessEXMEM),
        .funct3EXMEM(funct3EXMEM), .pc_src(pc_src), .branch_target(branch_target),
        .read_dataMEMWB(read_dataMEMWB), .alu_resultMEMWB(alu_resultMEMWB),
        .rdMEMWB(rdMEMWB), .MemtoRegMEMWB(MemtoRegMEMWB),
        .RegWriteMEMWB(RegWriteMEMWB), .wb_data(wb_data)
    );

    always #5 CLK = ~CLK;

    logic [7:0] ref_mem [MB];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       br;
        logic [2:0] f3;
        logic       z;
        logic       l;
        logic       exp;
    } br_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [2:0] f3);
        int unsigned n;
        logic [63:0] v;
        if (f3 == 3'b111) return 64'd0;
        n = 1 << f3[1:0];
        v = 64'd0;
        for (int unsigned i = 0; i < n; i++)
            v = v | (64'(ref_mem[(addr[7:0] + i) % MB]) << (8 * i));
        if (!f3[2] && n < 8 && v[8*n-1])
            v = v | ({64{1'b1}} << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [63:0] addr, input logic [63:0] data, input logic [2:0] f3);
        int unsigned n;
        if (f3[2]) return;
        n = 1 << f3[1:0];
        for (int unsigned i = 0; i < n; i++)
            ref_mem[(addr[7:0] + i) % MB] = 8'(data >> (8 * i));
    endtask

    function automatic logic model_branch(input logic b, input logic [2:0] f, input logic z, input logic l);
        logic c;
        c = (f == 3'd0 && z) || (f == 3'd1 && !z) ||
            ((f == 3'd4 || f == 3'd6) && l) || ((f == 3'd5 || f == 3'd7) && !l);
        return b && c;
    endfunction

    // One clocked step with current inputs; every output checked against the model.
    task automatic cycle();
        logic [63:0] e_rd, e_alu;
        logic [4:0]  e_rdn;
        logic        e_m2r, e_rw;
        #1;
        check("pc_src", 64'(pc_src), 64'(model_branch(BranchEXMEM, funct3EXMEM, zeroEXMEM, lessEXMEM)));
        check("branch_target", branch_target, next_pcEXMEM);
        e_rd  = MemReadEXMEM ? model_load(alu_resultEXMEM, funct3EXMEM) : 64'd0;
        e_alu = alu_resultEXMEM;
        e_rdn = rdEXMEM;
        e_m2r = MemtoRegEXMEM;
        e_rw  = RegWriteEXMEM;
        if (MemWriteEXMEM) model_store(alu_resultEXMEM, write_dataEXMEM, funct3EXMEM);
        @(posedge CLK);
        #1;
        check("read_data", read_dataMEMWB, e_rd);
        check("alu_result", alu_resultMEMWB, e_alu);
        check("rd", 64'(rdMEMWB), 64'(e_rdn));
        check("memtoreg", 64'(MemtoRegMEMWB), 64'(e_m2r));
        check("regwrite", 64'(RegWriteMEMWB), 64'(e_rw));
        check("wb_data", wb_data, e_m2r ? e_rd : e_alu);
    endtask

    task automatic op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] data);
        MemReadEXMEM    = rd_en;
        MemWriteEXMEM   = wr_en;
        funct3EXMEM     = f3;
        alu_resultEXMEM = addr;
        write_dataEXMEM = data;
        BranchEXMEM     = 1'b0;
        MemtoRegEXMEM   = rd_en;
        RegWriteEXMEM   = rd_en;
        rdEXMEM         = 5'($urandom);
        next_pcEXMEM    = {$urandom, $urandom};
        zeroEXMEM       = 1'($urandom);
        lessEXMEM       = 1'($urandom);
        cycle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_read_data"}, read_dataMEMWB, 64'd0);
        check({tag, "_alu_result"}, alu_resultMEMWB, 64'd0);
        check({tag, "_rd"}, 64'(rdMEMWB), 64'd0);
        check({tag, "_regwrite"}, 64'(RegWriteMEMWB), 64'd0);
        check({tag, "_wb_data"}, wb_data, 64'd0);
    endtask

    initial begin
        br_vec_t bv[$];
        logic [7:0] b30;

        bv.push_back('{1'b1, 3'b000, 1'b0, 1'b1, 1'b0});
        bv.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1'b1});
        bv.push_back('{1'b1, 3'b001, 1'b0, 1'b1, 1'b1});
        bv.push_back('{1'b1, 3'b001, 1'b1, 1'b0, 1'b0});
        bv.push_back('{1'b1, 3'b100, 1'b1, 1'b0, 1'b0});
        bv.push_back('{1'b1, 3'b100, 1'b0, 1'b1, 1'b1});
        bv.push_back('{1'b1, 3'b101, 1'b1, 1'b0, 1'b1});
        bv.push_back('{1'b1, 3'b101, 1'b0, 1'b1, 1'b0});
        bv.push_back('{1'b1, 3'b110, 1'b0, 1'b1, 1'b1});
        bv.push_back('{1'b1, 3'b111, 1'b0, 1'b1, 1'b0});
        bv.push_back('{1'b1, 3'b010, 1'b1, 1'b1, 1'b0});
        bv.push_back('{1'b1, 3'b011, 1'b1, 1'b1, 1'b0});
        bv.push_back('{1'b0, 3'b000, 1'b1, 1'b0, 1'b0});
        bv.push_back('{1'b0, 3'b101, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset at power-up.
        #1 RST = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b1;

        // Fill memory so every byte has a known value.
        for (int k = 0; k < 32; k++) op(1'b0, 1'b1, 3'b011, 64'(8 * k), {$urandom, $urandom});

        // sd / ld / lbu / lb
        op(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211);
        op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0);
        check("ld_0x10", read_dataMEMWB, 64'h8877665544332211);
        op(1'b1, 1'b0, 3'b100, 64'h17, 64'd0);
        check("lbu_0x17", read_dataMEMWB, 64'h88);
        op(1'b1, 1'b0, 3'b000, 64'h17, 64'd0);
        check("lb_0x17", read_dataMEMWB, 64'hFFFFFFFFFFFFFF88);

        // Wrapping word store at the top of memory.
        op(1'b0, 1'b1, 3'b010, 64'hFE, 64'h12345678DEADBEEF);
        op(1'b1, 1'b0, 3'b100, 64'hFE, 64'd0);
        check("byte_FE", read_dataMEMWB, 64'hEF);
        op(1'b1, 1'b0, 3'b100, 64'hFF, 64'd0);
        check("byte_FF", read_dataMEMWB, 64'hBE);
        op(1'b1, 1'b0, 3'b100, 64'h00, 64'd0);
        check("byte_00", read_dataMEMWB, 64'hAD);
        op(1'b1, 1'b0, 3'b100, 64'h01, 64'd0);
        check("byte_01", read_dataMEMWB, 64'hDE);
        op(1'b1, 1'b0, 3'b110, 64'hFE, 64'd0);
        check("lwu_wrap", read_dataMEMWB, 64'h00000000DEADBEEF);
        op(1'b1, 1'b0, 3'b010, 64'hFE, 64'd0);
        check("lw_wrap", read_dataMEMWB, 64'hFFFFFFFFDEADBEEF);

        // Same-cycle load and store: old contents returned.
        op(1'b0, 1'b1, 3'b000, 64'h20, 64'h11);
        op(1'b1, 1'b1, 3'b000, 64'h20, 64'h22);
        check("rbw_old", read_dataMEMWB, 64'h11);
        op(1'b1, 1'b0, 3'b000, 64'h20, 64'd0);
        check("rbw_new", read_dataMEMWB, 64'h22);

        // Branch condition table.
        MemReadEXMEM  = 1'b0;
        MemWriteEXMEM = 1'b0;
        foreach (bv[i]) begin
            BranchEXMEM  = bv[i].br;
            funct3EXMEM  = bv[i].f3;
            zeroEXMEM    = bv[i].z;
            lessEXMEM    = bv[i].l;
            next_pcEXMEM = {$urandom, $urandom};
            #1;
            check($sformatf("branch_vec%0d", i), 64'(pc_src), 64'(bv[i].exp));
            check($sformatf("target_vec%0d", i), branch_target, next_pcEXMEM);
            @(negedge CLK);
        end

        // Pass-through, then reset mid-cycle with a store pending.
        MemReadEXMEM    = 1'b0;
        MemWriteEXMEM   = 1'b0;
        BranchEXMEM     = 1'b0;
        RegWriteEXMEM   = 1'b1;
        MemtoRegEXMEM   = 1'b0;
        rdEXMEM         = 5'd5;
        alu_resultEXMEM = 64'h1234;
        cycle();
        check("wb_1234", wb_data, 64'h1234);
        check("rd_5", 64'(rdMEMWB), 64'd5);
        b30 = ref_mem[8'h30];
        MemWriteEXMEM   = 1'b1;
        funct3EXMEM     = 3'b000;
        alu_resultEXMEM = 64'h30;
        write_dataEXMEM = 64'hAA;
        #2 RST = 1'b0;
        #1 check_outputs_zero("midreset");
        @(posedge CLK);
        #1 MemWriteEXMEM = 1'b0;
        check_outputs_zero("held_reset");
        @(negedge CLK) RST = 1'b1;
        op(1'b1, 1'b0, 3'b100, 64'h30, 64'd0);
        check("byte_30_kept", read_dataMEMWB, 64'(b30));
        op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0);
        check("ld_after_reset", read_dataMEMWB, 64'h8877665544332211);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            MemReadEXMEM    = 1'($urandom);
            MemWriteEXMEM   = 1'($urandom);
            funct3EXMEM     = 3'($urandom);
            alu_resultEXMEM = {$urandom, $urandom};
            write_dataEXMEM = {$urandom, $urandom};
            BranchEXMEM     = 1'($urandom);
            MemtoRegEXMEM   = 1'($urandom);
            RegWriteEXMEM   = 1'($urandom);
            rdEXMEM         = 5'($urandom);
            next_pcEXMEM    = {$urandom, $urandom};
            zeroEXMEM       = 1'($urandom);
            lessEXMEM       = 1'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
